wb_dispatch: RTL
================

// Module: wb_dispatch
// PURPOSE
//  Write-back dispatch stage that sits directly upstream of the 1:8 demux in the
//  register write path. It queues register-write requests (3-bit address + data)
//  in a small FIFO and presents each one to the demux in two phases. First, sel
//  and wr_data are held stable for a setup cycle. Then the single-bit wr_en,
//  which is the demux 'in', is strobed for exactly one cycle. The demux fans
//  wr_en out to one of the eight register enables.
// PARAMETERS
//  DW     8   width of write data
//  DEPTH  4   request FIFO depth; power of two, >=2
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   1        write request present
//  req_ready  out  1        stage can accept a request
//  req_addr   in   3        destination register 0..7
//  req_data   in   DW       write data
//  hold       in   1        pipeline stall; freezes issue (not the FIFO)
//  flush      in   1        drop all queued and not-yet-strobed requests
//  sel        out  3        demux select (s[2:0])
//  wr_en      out  1        demux data input; one-cycle write strobe
//  wr_data    out  DW       data for the selected register
//  busy       out  1        state!=IDLE or FIFO non-empty
//  count      out  log2(DEPTH)+1   FIFO occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (async, on rst high): state=IDLE, FIFO empty, count=0, sel=0,
//   wr_data=0, wr_en=0, busy=0, req_ready=1. Takes effect immediately, mid-op
//   included; no strobe is issued after reset deasserts until a new request.
//  Handshake: push on the edge where req_valid&&req_ready.
//   req_ready = !full, where full means count==DEPTH. A pop in the same cycle
//   does not free a slot for a push while full. Requests are issued strictly in order.
//  Two-bit register state; wr_en = (state==STROBE); sel and wr_data are registers.
//  FSM:
//   IDLE:   if !empty && !hold && !flush -> pop head into sel/wr_data, go SETUP.
//   SETUP:  sel/wr_data stable, wr_en=0. If flush -> IDLE. Else if hold -> stay.
//           Else -> STROBE.
//   STROBE: wr_en=1 for exactly this cycle; hold is ignored because the write
//           is committed.
//           Next: if flush or empty or hold -> IDLE.
//           Else pop the next head into sel/wr_data -> SETUP.
//  Latency: request pushed at edge E0 -> SETUP after E1 -> wr_en high in the
//   cycle after E2. Sustained throughput is 1 write per 2 cycles.
//  sel and wr_data never change while wr_en=1. They change only on the edge
//   entering SETUP, so the demux select is settled a full cycle before the strobe.
//  Simultaneous push and pop (not full): both occur; count unchanged.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count distinguishes
//   full from empty.
//  flush (synchronous): FIFO emptied (count=0) on that edge; any push that
//   same cycle is discarded. A STROBE in progress still completes its cycle.
//   sel and wr_data keep their last values.
//  busy is combinational from state and count. No other combinational paths
//   run from inputs to outputs, except req_ready, which depends on count only.
// TESTING
//  1) Reset, then push addr=5,data=0xA5 at E0: sel=5 and wr_data=0xA5 after
//     E1, wr_en=1 only in the cycle after E2, then IDLE and busy=0.
//  2) Back-to-back push of addr 0..3 with data 0x10..0x13: strobes every 2nd
//     cycle, in order. sel is constant during each strobe and busy stays high
//     until the last strobe.
//  3) Hold off issue, push 5 requests with DEPTH=4: 4 accepted, req_ready=0,
//     count=4. The 5th stays pending until the first pop and is accepted the
//     cycle after.
//  4) Assert hold during SETUP for 3 cycles: sel is stable and wr_en=0
//     throughout. Release hold: exactly one strobe.
//  5) Queue 3 entries and assert flush during STROBE of the 1st: that strobe
//     completes, count=0 next cycle, no further wr_en, busy=0.
//  6) Assert rst in SETUP with count=2: wr_en never pulses, and all outputs
//     read their reset values immediately (before the next clk edge).

Source files
------------

// File: rtl/wb_dispatch.sv
// Write-back dispatch: queues register writes and presents each one to the 1:8 demux
// as a setup cycle (sel/wr_data settled) followed by a single-cycle wr_en strobe.
module wb_dispatch #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_addr,
    input  logic [DW-1:0] req_data,
    input  logic          hold,
    input  logic          flush,
    output logic [2:0]    sel,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    addr_mem_q [DEPTH];
    logic [2:0]    addr_mem_d [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [DW-1:0] data_mem_d [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = req_valid && !full && !flush;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_data_d  = wr_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty && !hold && !flush) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                // The strobe itself is committed; hold only blocks chaining the next request.
                if (flush || empty || hold) begin
                    state_d = IDLE;
                end else begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            sel_d     = addr_mem_q[rd_ptr_q];
            wr_data_d = data_mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end

        if (push) begin
            addr_mem_d[wr_ptr_q] = req_addr;
            data_mem_d[wr_ptr_q] = req_data;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            wr_data_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wr_data_q  <= wr_data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    assign req_ready = !full;
    assign sel       = sel_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = (state_q == STROBE);
    assign busy      = (state_q != IDLE) || !empty;
    assign count     = count_q;

endmodule
